prog_loader: RTL

- Upstream feeder for the 256 x 12-bit program memory's load port (write enable, write address, write data).
- Receives a framed byte stream from the host byte receiver over a valid/ready handshake. Packs each pair of bytes into one 12-bit instruction and writes instructions to consecutive addresses starting at 0.
- Verifies an XOR checksum at the end of the frame.
- Holds the CPU stalled until a frame loads cleanly.

---
 rtl/prog_loader.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Feeds the load port of the 256 x 12-bit program memory from a framed host
// byte stream. A frame is LEN, then LEN (HI, LO) pairs, then CSUM. Each pair
// becomes one 12-bit instruction {HI[3:0], LO}, written to consecutive
// addresses starting at 0. CSUM must equal the XOR of LEN and every HI/LO
// byte. The CPU is held stalled until a frame has loaded cleanly.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   start       one-cycle frame request (honoured in IDLE, DONE, ERR)
//   rx_data     incoming byte
//   rx_valid    rx_data valid
//   rx_ready    loader accepts a byte this cycle (depends on state only)
//   load_en     program memory write strobe (registered, one cycle)
//   load_addr   program memory write address (registered)
//   load_instr  program memory write data (registered)
//   busy        a frame is in progress
//   done        sticky: last frame loaded with good checksum
//   error       sticky: last frame aborted
//   error_code  01 format, 10 checksum, 11 timeout, 00 none
//   cpu_hold    CPU stall while program memory is not valid
// -----------------------------------------------------------------------------
module prog_loader #(
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  load_en,
    output logic [ADDR_WIDTH-1:0] load_addr,
    output logic [11:0]           load_instr,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            error_code,
    output logic                  cpu_hold
);

    typedef enum logic [2:0] {
        IDLE,
        GET_LEN,
        GET_HI,
        GET_LO,
        WRITE,
        GET_CSUM,
        DONE,
        ERR
    } state_t;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_FORMAT = 2'b01;
    localparam logic [1:0] ERR_CSUM   = 2'b10;
    localparam logic [1:0] ERR_TMO    = 2'b11;

    // Instruction count needs one extra bit so that LEN=0 can mean 256.
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    logic [7:0]            acc_q, acc_d;
    logic [CNT_W-1:0]      len_q, len_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [3:0]            nib_q, nib_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [1:0]            err_code_q, err_code_d;
    logic                  load_en_q, load_en_d;
    logic [ADDR_WIDTH-1:0] load_addr_q, load_addr_d;
    logic [11:0]           load_instr_q, load_instr_d;

    logic xfer;

    // Handshake and status flags are pure decodes of the state register.
    assign rx_ready   = (state_q == GET_LEN) || (state_q == GET_HI) ||
                        (state_q == GET_LO)  || (state_q == GET_CSUM);
    assign busy       = rx_ready || (state_q == WRITE);
    assign done       = (state_q == DONE);
    assign error      = (state_q == ERR);
    assign cpu_hold   = (state_q != DONE);
    assign error_code = err_code_q;
    assign load_en    = load_en_q;
    assign load_addr  = load_addr_q;
    assign load_instr = load_instr_q;

    assign xfer = rx_valid && rx_ready;

    // NOTE: every variable gets its default before the case statement so no
    // path leaves one unassigned; that is what keeps this block latch-free.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        nib_d        = nib_q;
        tmo_d        = tmo_q;
        err_code_d   = err_code_q;
        load_en_d    = 1'b0;
        load_addr_d  = load_addr_q;
        load_instr_d = load_instr_q;

        // Inter-byte timer: runs while waiting for a byte, cleared by a byte.
        if (rx_ready) begin
            if (xfer) tmo_d = '0;
            else      tmo_d = tmo_q + TMO_W'(1);
        end

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d     = GET_LEN;
                    err_code_d  = ERR_NONE;
                    acc_d       = '0;
                    cnt_d       = '0;
                    tmo_d       = '0;
                    load_addr_d = '0;
                end
            end
            GET_LEN: begin
                if (xfer) begin
                    len_d   = (rx_data == 8'd0) ? CNT_W'(256) : CNT_W'(rx_data);
                    acc_d   = acc_q ^ rx_data;
                    state_d = GET_HI;
                end
            end
            GET_HI: begin
                if (xfer) begin
                    acc_d = acc_q ^ rx_data;
                    if (rx_data[7:4] != 4'd0) begin
                        state_d    = ERR;
                        err_code_d = ERR_FORMAT;
                    end else begin
                        nib_d   = rx_data[3:0];
                        state_d = GET_LO;
                    end
                end
            end
            GET_LO: begin
                if (xfer) begin
                    acc_d        = acc_q ^ rx_data;
                    // Load port outputs are registered, so they are set up on
                    // the edge entering WRITE and are valid during WRITE.
                    load_instr_d = {nib_q, rx_data};
                    load_en_d    = 1'b1;
                    state_d      = WRITE;
                end
            end
            WRITE: begin
                // Address wraps naturally after the last location; the
                // instruction count, not the address, ends the frame.
                load_addr_d = load_addr_q + ADDR_WIDTH'(1);
                cnt_d       = cnt_q + CNT_W'(1);
                state_d     = ((cnt_q + CNT_W'(1)) == len_q) ? GET_CSUM : GET_HI;
            end
            GET_CSUM: begin
                if (xfer) begin
                    if (rx_data == acc_q) begin
                        state_d = DONE;
                    end else begin
                        state_d    = ERR;
                        err_code_d = ERR_CSUM;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A byte arriving on the expiry cycle wins over the timeout.
        if (rx_ready && !xfer && (tmo_q == TMO_LAST)) begin
            state_d    = ERR;
            err_code_d = ERR_TMO;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before this edge, independent of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            nib_q        <= '0;
            tmo_q        <= '0;
            err_code_q   <= ERR_NONE;
            load_en_q    <= 1'b0;
            load_addr_q  <= '0;
            load_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            nib_q        <= nib_d;
            tmo_q        <= tmo_d;
            err_code_q   <= err_code_d;
            load_en_q    <= load_en_d;
            load_addr_q  <= load_addr_d;
            load_instr_q <= load_instr_d;
        end
    end

endmodule
